// File: rtl/fifo_sync_param.sv
//==============================================================================
// Module  : fifo_sync_param
// Brief   : Single-clock FIFO with wrap-bit pointers, occupancy count,
//           almost-full/empty flags, sticky error flags and optional FWFT read.
// Revision: 1.0
//==============================================================================
`default_nettype none

module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        r_en,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] c_ONE      = PW'(1);
    localparam logic [PW-1:0] c_AF_LEVEL = PW'(AF_LEVEL);
    localparam logic [PW-1:0] c_AE_LEVEL = PW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [AW-1:0]         w_wr_addr;
    logic [AW-1:0]         w_rd_addr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_wr_addr = r_wr_ptr[AW-1:0];
    assign w_rd_addr = r_rd_ptr[AW-1:0];

    // Same address with differing wrap bits means the writer is a full lap ahead.
    assign w_full  = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_wr_acc = w_en & ~w_full;
    assign w_rd_acc = r_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_ONE;

            if (w_wr_acc && !w_rd_acc)      r_count <= r_count + c_ONE;
            else if (w_rd_acc && !w_wr_acc) r_count <= r_count - c_ONE;

            // A new error event takes priority over a simultaneous clear.
            if (w_en && w_full)  r_overflow <= 1'b1;
            else if (err_clr)    r_overflow <= 1'b0;
            if (r_en && w_empty) r_underflow <= 1'b1;
            else if (err_clr)    r_underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) r_mem[w_wr_addr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = w_empty ? '0 : r_mem[w_rd_addr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            always_ff @(posedge clk) begin
                if (!rst_n)        r_data_out <= '0;
                else if (w_rd_acc) r_data_out <= r_mem[w_rd_addr];
            end
            assign data_out = r_data_out;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF_LEVEL);
    assign almost_empty = (r_count <= c_AE_LEVEL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
//==============================================================================
// Module  : tb_fifo_sync_param
// Brief   : Directed self-checking bench for fifo_sync_param (standard + FWFT).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst_n;
    int         total = 0;
    int         bad   = 0;

    // Standard-read instance
    logic       w_en, r_en, err_clr;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    // FWFT instance
    logic       f_w_en, f_r_en, f_err_clr;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .w_en(f_w_en), .data_in(f_data_in), .r_en(f_r_en),
        .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow), .err_clr(f_err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            bad++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, almost_empty, almost_full}); end
        total++; if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", data_out); end
        total++; if (f_data_out !== 8'h00 || f_empty !== 1'b1) begin
            bad++; $display("FAIL reset_fwft got=%h/%b exp=00/1", f_data_out, f_empty); end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1; data_in = 8'(i);
            tick();
            total++; if (count !== 5'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
            total++; if ({almost_empty, almost_full, full, overflow} !== {i <= 2, i >= 14, i == 16, 1'b0}) begin
                bad++; $display("FAIL fill_flags[%0d] got=%b exp=%b", i,
                    {almost_empty, almost_full, full, overflow}, {i <= 2, i >= 14, i == 16, 1'b0}); end
        end
        w_en = 1'b0;
    endtask

    task automatic test_overflow_drain();
        w_en = 1'b1; data_in = 8'hAA;
        tick();
        w_en = 1'b0;
        total++; if (count !== 5'd16 || full !== 1'b1) begin
            bad++; $display("FAIL ovf_count got=%0d/%b exp=16/1", count, full); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int i = 0; i < 16; i++) begin
            r_en = 1'b1;
            tick();
            total++; if (data_out !== 8'(i + 1)) begin
                bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, 8'(i + 1)); end
        end
        r_en = 1'b0;
        total++; if (empty !== 1'b1 || count !== 5'd0) begin
            bad++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_underflow();
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", underflow); end
        total++; if (data_out !== 8'h10 || count !== 5'd0) begin
            bad++; $display("FAIL unf_hold got=%h/%0d exp=10/0", data_out, count); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL err_clr got=%b exp=00", {overflow, underflow}); end
        err_clr = 1'b1; r_en = 1'b1;
        tick();
        err_clr = 1'b0; r_en = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", underflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; data_in = 8'(8'h20 + i);
            tick();
        end
        total++; if (count !== 5'd8) begin bad++; $display("FAIL b2b_prefill got=%0d exp=8", count); end
        for (int i = 0; i < 40; i++) begin
            w_en = 1'b1; r_en = 1'b1; data_in = 8'(8'h28 + i);
            tick();
            total++; if (count !== 5'd8 || data_out !== 8'(8'h20 + i)) begin
                bad++; $display("FAIL b2b[%0d] got=%0d/%h exp=8/%h", i, count, data_out, 8'(8'h20 + i)); end
        end
        w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 2; i++) begin
            w_en = 1'b1; data_in = 8'hC0;
            tick();
        end
        w_en = 1'b0;
        total++; if (count !== 5'd10 || underflow !== 1'b1) begin
            bad++; $display("FAIL midop_pre got=%0d/%b exp=10/1", count, underflow); end
        rst_n = 1'b0; w_en = 1'b1; data_in = 8'hEE;
        tick();
        rst_n = 1'b1; w_en = 1'b0;
        total++; if (count !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00) begin
            bad++; $display("FAIL midop_rst got=%0d/%b/%h exp=0/1/00", count, empty, data_out); end
        total++; if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL midop_err got=%b exp=00", {overflow, underflow}); end
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        total++; if (underflow !== 1'b1 || count !== 5'd0) begin
            bad++; $display("FAIL midop_read got=%b/%0d exp=1/0", underflow, count); end
    endtask

    task automatic test_fwft();
        f_w_en = 1'b1; f_data_in = 8'h5A;
        tick();
        f_w_en = 1'b0;
        total++; if (f_data_out !== 8'h5A || f_empty !== 1'b0) begin
            bad++; $display("FAIL fwft_first got=%h/%b exp=5a/0", f_data_out, f_empty); end
        f_w_en = 1'b1; f_data_in = 8'h5B;
        tick();
        f_w_en = 1'b0;
        total++; if (f_data_out !== 8'h5A || f_count !== 5'd2) begin
            bad++; $display("FAIL fwft_hold got=%h/%0d exp=5a/2", f_data_out, f_count); end
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        total++; if (f_data_out !== 8'h5B || f_count !== 5'd1) begin
            bad++; $display("FAIL fwft_pop got=%h/%0d exp=5b/1", f_data_out, f_count); end
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        total++; if (f_empty !== 1'b1 || f_data_out !== 8'h00) begin
            bad++; $display("FAIL fwft_empty got=%b/%h exp=1/00", f_empty, f_data_out); end
    endtask

    initial begin
        rst_n = 1'b1; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;
        f_w_en = 1'b0; f_r_en = 1'b0; f_err_clr = 1'b0; f_data_in = 8'h00;
        #2;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_back_to_back();
        test_reset_midop();
        test_fwft();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
